// File: rtl/mem_access_unit.sv
// LC-3b memory-stage controller: drives the data port of the shared block RAM,
// formats load data and returns one response per request to writeback.
module mem_access_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_dr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we_low,
    output logic              mem_we_high,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [2:0]        resp_dr,
    output logic              resp_is_load,
    output logic              resp_fault
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    localparam logic [1:0] OP_LDW = 2'b00;
    localparam logic [1:0] OP_LDB = 2'b01;
    localparam logic [1:0] OP_STW = 2'b10;
    localparam logic [1:0] OP_STB = 2'b11;

    state_t              state_reg;
    logic [1:0]          op_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   resp_data_reg;
    logic [2:0]          resp_dr_reg;
    logic                resp_valid_reg;
    logic                resp_is_load_reg;
    logic                resp_fault_reg;

    logic                accept;
    logic                word_misaligned;
    logic [7:0]          load_byte;
    logic [DATA_W-1:0]   load_data;

    assign req_ready = (state_reg == IDLE) & ~reset;
    assign accept    = req_valid & req_ready;

    // op[0]==0 marks the word ops (LDW/STW); they fault on an odd address.
    assign word_misaligned = ~req_op[0] & req_addr[0];

    assign mem_addr  = addr_reg;
    assign mem_wdata = (op_reg == OP_STW) ? wdata_reg : {wdata_reg[7:0], wdata_reg[7:0]};

    // Enables are gated by reset combinationally so a reset during ACCESS drops the write.
    assign mem_we_low  = (state_reg == ACCESS) & ~reset &
                         ((op_reg == OP_STW) | ((op_reg == OP_STB) & ~addr_reg[0]));
    assign mem_we_high = (state_reg == ACCESS) & ~reset &
                         ((op_reg == OP_STW) | ((op_reg == OP_STB) & addr_reg[0]));

    assign load_byte = addr_reg[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    assign load_data = (op_reg == OP_LDB) ? {{(DATA_W-8){load_byte[7]}}, load_byte} : mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            op_reg           <= OP_LDW;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            resp_data_reg    <= '0;
            resp_dr_reg      <= '0;
            resp_valid_reg   <= 1'b0;
            resp_is_load_reg <= 1'b0;
            resp_fault_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg           <= req_op;
                        addr_reg         <= req_addr;
                        wdata_reg        <= req_wdata;
                        resp_dr_reg      <= req_dr;
                        resp_is_load_reg <= ~req_op[1];
                        resp_fault_reg   <= word_misaligned;
                        resp_data_reg    <= '0;
                        if (word_misaligned) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (op_reg[1]) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                    end else begin
                        state_reg <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    resp_data_reg  <= load_data;
                    state_reg      <= RESP;
                    resp_valid_reg <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign resp_valid   = resp_valid_reg;
    assign resp_data    = resp_data_reg;
    assign resp_dr      = resp_dr_reg;
    assign resp_is_load = resp_is_load_reg;
    assign resp_fault   = resp_fault_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: block-RAM stand-in plus a word-array reference model
// that predicts load data, latency and fault outcome per request.
module tb_mem_access_unit;

    localparam logic [1:0] LDW = 2'b00, LDB = 2'b01, STW = 2'b10, STB = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [2:0]  req_dr = '0;
    logic [15:0] mem_addr;
    logic        mem_we_low;
    logic        mem_we_high;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_data;
    logic [2:0]  resp_dr;
    logic        resp_is_load;
    logic        resp_fault;

    int checks = 0;
    int passes = 0;

    logic [15:0] ram [0:32767];
    logic [15:0] ref_word [0:32767];

    mem_access_unit #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_dr(req_dr),
        .mem_addr(mem_addr), .mem_we_low(mem_we_low), .mem_we_high(mem_we_high),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_dr(resp_dr), .resp_is_load(resp_is_load), .resp_fault(resp_fault)
    );

    always #5 clk = ~clk;

    // Block RAM stand-in: byte-lane writes, registered read.
    always @(posedge clk) begin
        if (mem_we_low)  ram[mem_addr[15:1]][7:0]  <= mem_wdata[7:0];
        if (mem_we_high) ram[mem_addr[15:1]][15:8] <= mem_wdata[15:8];
        mem_rdata <= ram[mem_addr[15:1]];
    end

    function automatic bit model_fault(input logic [1:0] op, input logic [15:0] addr);
        return (op == LDW || op == STW) && (addr % 2 == 1);
    endfunction

    function automatic int model_latency(input logic [1:0] op, input logic [15:0] addr);
        if (model_fault(op, addr)) return 1;
        if (op == STW || op == STB) return 2;
        return 3;
    endfunction

    function automatic logic [15:0] model_data(input logic [1:0] op, input logic [15:0] addr);
        logic [15:0] w;
        int b;
        if (model_fault(op, addr) || op == STW || op == STB) return 16'h0000;
        w = ref_word[addr / 2];
        if (op == LDW) return w;
        b = (addr % 2 == 1) ? (w / 256) : (w % 256);
        return (b >= 128) ? 16'(b + 16'hFF00) : 16'(b);
    endfunction

    task automatic model_store(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata);
        int i;
        i = addr / 2;
        if (model_fault(op, addr)) return;
        if (op == STW)
            ref_word[i] = wdata;
        else if (op == STB && addr % 2 == 1)
            ref_word[i] = (ref_word[i] & 16'h00FF) | 16'((wdata % 256) * 256);
        else if (op == STB)
            ref_word[i] = (ref_word[i] & 16'hFF00) | 16'(wdata % 256);
    endtask

    // Issues one request and observes the response; comparisons are made by the callers.
    task automatic run_txn(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [2:0] dr, input int hold,
                           output int lat, output logic [15:0] data, output logic fault,
                           output logic is_load, output logic [2:0] dr_o,
                           output int we_lo, output int we_hi, output logic resp_ok, output logic rdy_ok);
        @(negedge clk);
        rdy_ok     = req_ready;
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_wdata  = wdata;
        req_dr     = dr;
        resp_ready = 1'b0;
        lat = 0; we_lo = 0; we_hi = 0;
        do begin
            @(negedge clk);
            lat++;
            req_valid = 1'b0;
            req_op    = 2'(op + 1);
            if (mem_we_low)  we_lo++;
            if (mem_we_high) we_hi++;
        end while (!resp_valid && lat < 20);
        data = resp_data; fault = resp_fault; is_load = resp_is_load; dr_o = resp_dr;
        resp_ok = resp_valid;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_data !== data || resp_fault !== fault || req_ready !== 1'b0)
                resp_ok = 1'b0;
            if (mem_we_low)  we_lo++;
            if (mem_we_high) we_hi++;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) resp_ok = 1'b0;
        $display("txn op=%0d addr=%h wdata=%h dr=%0d lat=%0d data=%h fault=%0b load=%0b",
                 op, addr, wdata, dr, lat, data, fault, is_load);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) $display("FAIL reset_ready_low got=%b want=0", req_ready);
        else passes++;
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", req_ready);
        else passes++;
        checks++;
        if ({resp_valid, resp_data, resp_dr, resp_is_load, resp_fault} !== 22'd0)
            $display("FAIL reset_resp got=%b_%h_%0d_%b_%b want=all zero",
                     resp_valid, resp_data, resp_dr, resp_is_load, resp_fault);
        else passes++;
        checks++;
        if ({mem_addr, mem_wdata, mem_we_low, mem_we_high} !== 34'd0)
            $display("FAIL reset_mem got=%h_%h_%b_%b want=all zero", mem_addr, mem_wdata, mem_we_low, mem_we_high);
        else passes++;
    endtask

    // Directed transaction with full field checks against the model.
    task automatic check_txn(input string name, input logic [1:0] op, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [2:0] dr, input int hold,
                             input int exp_lo, input int exp_hi);
        int lat, we_lo, we_hi;
        logic [15:0] data, exp_data;
        logic fault, is_load, resp_ok, rdy_ok;
        logic [2:0] dr_o;
        exp_data = model_data(op, addr);
        run_txn(op, addr, wdata, dr, hold, lat, data, fault, is_load, dr_o, we_lo, we_hi, resp_ok, rdy_ok);
        model_store(op, addr, wdata);
        checks++;
        if (lat != model_latency(op, addr)) $display("FAIL %s_latency got=%0d want=%0d", name, lat, model_latency(op, addr));
        else passes++;
        checks++;
        if (data !== exp_data) $display("FAIL %s_data got=%h want=%h", name, data, exp_data);
        else passes++;
        checks++;
        if (fault !== model_fault(op, addr) || is_load !== ~op[1] || dr_o !== dr)
            $display("FAIL %s_flags got=f%b l%b d%0d want=f%b l%b d%0d", name, fault, is_load, dr_o,
                     model_fault(op, addr), ~op[1], dr);
        else passes++;
        checks++;
        if (we_lo != exp_lo || we_hi != exp_hi)
            $display("FAIL %s_we got=lo%0d hi%0d want=lo%0d hi%0d", name, we_lo, we_hi, exp_lo, exp_hi);
        else passes++;
        checks++;
        if (!resp_ok || !rdy_ok) $display("FAIL %s_handshake got=resp%b rdy%b want=1 1", name, resp_ok, rdy_ok);
        else passes++;
    endtask

    task automatic test_ldw();
        check_txn("ldw_1234", LDW, 16'h1234, 16'h0, 3'd5, 0, 0, 0);
    endtask

    task automatic test_ldb();
        check_txn("ldb_0080", LDB, 16'h0080, 16'h0, 3'd1, 0, 0, 0);
        check_txn("ldb_0102", LDB, 16'h0102, 16'h0, 3'd2, 0, 0, 0);
        check_txn("ldb_0103", LDB, 16'h0103, 16'h0, 3'd3, 0, 0, 0);
    endtask

    task automatic test_stb();
        check_txn("stb_2001", STB, 16'h2001, 16'h00AB, 3'd4, 0, 0, 1);
        check_txn("ldw_2000", LDW, 16'h2000, 16'h0, 3'd6, 0, 0, 0);
    endtask

    task automatic test_fault();
        check_txn("stw_3003", STW, 16'h3003, 16'hBEEF, 3'd7, 0, 0, 0);
        check_txn("ldw_3002", LDW, 16'h3002, 16'h0, 3'd0, 0, 0, 0);
        check_txn("ldw_odd", LDW, 16'h1235, 16'h0, 3'd2, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        check_txn("ldw_hold", LDW, 16'h0ABC, 16'h0, 3'd5, 5, 0, 0);
        check_txn("stw_hold", STW, 16'h0AC0, 16'hCAFE, 3'd1, 3, 1, 1);
    endtask

    task automatic test_reset_access();
        @(negedge clk);
        req_valid = 1'b1; req_op = STW; req_addr = 16'h5000; req_wdata = 16'h1111; req_dr = 3'd3;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (mem_we_low !== 1'b1 || mem_we_high !== 1'b1 || mem_wdata !== 16'h1111)
            $display("FAIL rst_access_pre got=%b%b %h want=11 1111", mem_we_low, mem_we_high, mem_wdata);
        else passes++;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_we_low !== 1'b0 || mem_we_high !== 1'b0)
            $display("FAIL rst_access_we got=%b%b want=00", mem_we_low, mem_we_high);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL rst_access_idle got=v%b r%b want=v0 r1", resp_valid, req_ready);
        else passes++;
        check_txn("ldw_5000", LDW, 16'h5000, 16'h0, 3'd3, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op;
            logic [15:0] addr, wdata, exp_data;
            logic [2:0]  dr, dr_o;
            int lat, we_lo, we_hi;
            logic [15:0] data;
            logic fault, is_load, resp_ok, rdy_ok;
            op    = 2'($urandom_range(0, 3));
            addr  = 16'h4000 + 16'($urandom_range(0, 15));
            wdata = 16'($urandom);
            dr    = 3'($urandom_range(0, 7));
            exp_data = model_data(op, addr);
            run_txn(op, addr, wdata, dr, int'($urandom_range(0, 2)), lat, data, fault, is_load, dr_o,
                    we_lo, we_hi, resp_ok, rdy_ok);
            model_store(op, addr, wdata);
            checks++;
            if (lat != model_latency(op, addr) || data !== exp_data || fault !== model_fault(op, addr) ||
                is_load !== ~op[1] || dr_o !== dr || !resp_ok || !rdy_ok)
                $display("FAIL rand_%0d got=lat%0d d%h f%b l%b t%0d ok%b%b want=lat%0d d%h f%b l%b t%0d ok11",
                         n, lat, data, fault, is_load, dr_o, resp_ok, rdy_ok,
                         model_latency(op, addr), exp_data, model_fault(op, addr), ~op[1], dr);
            else passes++;
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            ram[i]      = 16'(i * 2);
            ref_word[i] = 16'(i * 2);
        end
        test_reset();
        test_ldw();
        test_ldb();
        test_stb();
        test_fault();
        test_backpressure();
        test_reset_access();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage controller for the LC-3b pipeline. It sits directly upstream of the data port (port 2) of the shared block-RAM memory and drives its address, byte write enables and write data. It captures the read data one cycle after the address is presented, then formats it: byte select and sign extension for LDB, pass-through for LDW. It returns one response per request to writeback through a valid/ready handshake, and it faults word accesses to odd addresses.

Parameters:
ADDR_W, 16, byte address width; memory is byte addressed and word index = addr[15:1]
DATA_W, 16, data word width; byte lanes are [7:0] (even address) and [15:8] (odd address)

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  1  access request present
req_ready  output  1  unit accepts a request this cycle
req_op  input  2  00 LDW, 01 LDB, 10 STW, 11 STB
req_addr  input  16  byte address
req_wdata  input  16  store data; STB uses [7:0]
req_dr  input  3  destination register tag, passed through unchanged
mem_addr  output  16  to memory port-2 address
mem_we_low  output  1  to memory low-byte write enable
mem_we_high  output  1  to memory high-byte write enable
mem_wdata  output  16  to memory write data
mem_rdata  input  16  from memory port-2 read data; valid the cycle after the address edge
resp_valid  output  1  response valid
resp_ready  input  1  writeback accepts response
resp_data  output  16  load result; 0 for stores and faults
resp_dr  output  3  tag of the completed request
resp_is_load  output  1  1 for LDW/LDB
resp_fault  output  1  unaligned word access

Behaviour:
- Integration: the memory enable is tied to 1 at top level. This unit never drives it.
- FSM states: IDLE, ACCESS, CAPTURE, RESP. req_ready = (state==IDLE) & ~reset.
- Reset: state IDLE. Output registers clear: resp_valid=0, resp_data=0, resp_dr=0, resp_is_load=0, resp_fault=0, latched addr/op/wdata=0, so mem_addr=0, mem_wdata=0 and both write enables are 0.
- IDLE, on accept (req_valid & req_ready): latch op, addr, wdata, dr.
  - Word op (LDW/STW) with addr[0]=1: go directly to RESP with resp_fault=1 and resp_data=0. No memory write ever occurs for the faulted request.
  - Otherwise: go to ACCESS.
- mem_addr always equals the latched address. mem_wdata = STW ? wdata : {wdata[7:0], wdata[7:0]}.
- ACCESS (exactly 1 cycle):
  - mem_we_low = ~reset & (STW | (STB & ~a0)).
  - mem_we_high = ~reset & (STW | (STB & a0)).
  - Both enables are 0 in every other state.
  - Next state: CAPTURE for loads, RESP for stores.
- CAPTURE (1 cycle): register the formatted mem_rdata into resp_data.
  - LDW: resp_data = mem_rdata.
  - LDB: the selected byte (a0 ? [15:8] : [7:0]) sign-extended to 16 bits.
  - Next state: RESP.
- RESP: resp_valid=1. resp_data, resp_dr, resp_is_load and resp_fault are stable until resp_valid & resp_ready. On that handshake go to IDLE and clear resp_valid. A new request cannot be accepted in the same cycle as the handshake.
- Latency, accept edge to resp_valid high:
  - Load: 3 cycles.
  - Store: 2 cycles.
  - Fault: 1 cycle.
  - Minimum issue interval: 4 cycles (load), 3 (store), 2 (fault), assuming resp_ready is held high.
- Backpressure: resp_ready held low keeps the unit in RESP indefinitely with outputs frozen and req_ready=0.
- Reset during any state returns to IDLE on that edge and drops the in-flight request. Reset high during ACCESS suppresses the write, because the enables are gated by ~reset combinationally.
- Byte lane rule: an even address selects the low byte and an odd address selects the high byte, for both loads and stores.
- req_* inputs are ignored outside IDLE.

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0, req_ready=1 on the first post-reset cycle.
- LDW 0x1234 (memory power-up image: word at even addr A = A) -> resp_valid exactly 3 cycles after accept; resp_data=0x1234, resp_is_load=1, resp_fault=0, resp_dr echoed.
- LDB 0x0080 -> resp_data=0xFF80 (sign extended). LDB 0x0102 -> 0x0002. LDB 0x0103 -> 0x0001.
- STB 0x2001 with wdata 0x00AB -> mem_we_high=1 and mem_we_low=0 for exactly one cycle, resp after 2 cycles. Then LDW 0x2000 -> 0xAB00.
- STW 0x3003 with wdata 0xBEEF -> resp_fault=1 after 1 cycle, both write enables never asserted. Then LDW 0x3002 -> 0x3002 (unchanged).
- LDW with resp_ready=0 for 5 cycles -> resp_valid and resp_data held, req_ready=0. Also: STW with reset asserted during the ACCESS cycle -> no write, and a later LDW returns the original word.
